mcse_auth_sequencer: RTL and testbench

Parametrised firmware-authentication sequencer for the minimum security module. On `start`, it walks up to NUM_IP IP images in memory. For each image it fetches the data through the bus-translation request port in 128-bit beats, packs the beats into 512-bit SHA-256 blocks, and drives the SHA core through init/next. It then compares each final digest with a per-IP golden digest and reports per-IP pass/fail, with optional timeout and lock-on-fail modes. It sits between boot control and the `sha_top` / `bus_translation` instances.

---
 rtl/mcse_auth_sequencer_pkg.sv | 28 ++
 rtl/mcse_auth_sequencer_if.sv | 28 ++
 rtl/mcse_block_packer.sv | 29 ++
 rtl/mcse_auth_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mcse_auth_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcse_auth_sequencer_pkg.sv
// Shared types, widths and the beat-address helper for the firmware authentication sequencer.
package mcse_auth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RD_REQ,
        S_RD_WAIT,
        S_SHA_ISSUE,
        S_SHA_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int DIGEST_W      = 256;
    localparam int BLOCK_W       = 512;
    localparam int BEAT_W        = 128;
    localparam int BEATS_PER_BLK = 4;
    localparam int BEAT_CNT_W    = $clog2(BEATS_PER_BLK);

    // Byte address of one beat; the caller truncates to its bus width, so it wraps.
    function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [63:0] stride,
                                              input logic [63:0] ip, input logic [63:0] blk,
                                              input logic [63:0] beat);
        return base + ip * stride + (blk * 64'(BEATS_PER_BLK) + beat) * 64'(BEAT_W / 8);
    endfunction

endpackage

// File: rtl/mcse_auth_sequencer_if.sv
// Bus-translation read port and SHA core command/result port of the sequencer.
interface mcse_auth_sequencer_if #(parameter int ADDR_W = 32);
    import mcse_auth_pkg::*;

    logic                bus_go;
    logic [ADDR_W-1:0]   bus_addr;
    logic                bus_RW;
    logic [BEAT_W-1:0]   bus_write;
    logic                bus_done;
    logic [BEAT_W-1:0]   bus_rdData;
    logic [BLOCK_W-1:0]  sha_block;
    logic                sha_init;
    logic                sha_next;
    logic                sha_ready;
    logic [DIGEST_W-1:0] sha_digest;
    logic                sha_digest_valid;

    modport master (
        output bus_go, bus_addr, bus_RW, bus_write, sha_block, sha_init, sha_next,
        input  bus_done, bus_rdData, sha_ready, sha_digest, sha_digest_valid
    );

    modport slave (
        input  bus_go, bus_addr, bus_RW, bus_write, sha_block, sha_init, sha_next,
        output bus_done, bus_rdData, sha_ready, sha_digest, sha_digest_valid
    );

endinterface

// File: rtl/mcse_block_packer.sv
// Packs 128-bit read beats into a 512-bit SHA block, beat 0 landing in the MSB slice.
module mcse_block_packer import mcse_auth_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [BEAT_W-1:0]     data,
    output logic [BEAT_CNT_W-1:0] beat,
    output logic                  last,
    output logic [BLOCK_W-1:0]    block
);

    assign last = (beat == BEAT_CNT_W'(BEATS_PER_BLK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat  <= '0;
            block <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (load) begin
            for (int i = 0; i < BEATS_PER_BLK; i++)
                if (beat == BEAT_CNT_W'(i))
                    block[BLOCK_W-1-BEAT_W*i -: BEAT_W] <= data;
            beat <= beat + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mcse_auth_sequencer.sv
// Walks the masked-in IP images, hashes each through the SHA core and checks the
// final digest against its golden value, with timeout and lock-on-fail handling.
module mcse_auth_sequencer import mcse_auth_pkg::*; #(
    parameter int                NUM_IP         = 4,
    parameter int                BLOCKS_PER_IMG = 2,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [ADDR_W-1:0] IP_STRIDE      = ADDR_W'(32'h0000_1000),
    parameter int                TIMEOUT_CYC    = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [NUM_IP-1:0]                           ip_mask,
    input  logic                                        lock_on_fail,
    input  logic [NUM_IP*DIGEST_W-1:0]                  golden_digest,
    mcse_auth_sequencer_if.master                       bif,
    output logic                                        busy,
    output logic                                        done,
    output logic [NUM_IP-1:0]                           pass_vec,
    output logic [NUM_IP-1:0]                           fail_vec,
    output logic                                        timeout_err,
    output logic [(NUM_IP > 1 ? $clog2(NUM_IP) : 1)-1:0] cur_ip
);

    localparam int IP_W  = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
    localparam int BLK_W = (BLOCKS_PER_IMG > 1) ? $clog2(BLOCKS_PER_IMG) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t                state, state_nx;
    logic [IP_W-1:0]       cur_ip_nx, sel_idx;
    logic [BLK_W-1:0]      blk, blk_nx;
    logic                  ip_end, ip_end_nx;
    logic [NUM_IP-1:0]     mask_q;
    logic                  lock_q;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  tmo_hit, hold_done, waiting, sel_found;
    logic [BEAT_CNT_W-1:0] beat, addr_beat;
    logic                  pk_clr, pk_load, pk_last;
    logic                  clr_res, set_pass, set_fail, set_tmo, ip_fail, advance;
    logic [DIGEST_W-1:0]   gold;
    logic [63:0]           addr_full;
    logic [BLOCK_W-1:0]    block_q;
    logic                  bus_go_q, sha_init_q, sha_next_q;
    logic [ADDR_W-1:0]     bus_addr_q;

    assign bif.bus_go    = bus_go_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_RW    = 1'b0;
    assign bif.bus_write = '0;
    assign bif.sha_block = block_q;
    assign bif.sha_init  = sha_init_q;
    assign bif.sha_next  = sha_next_q;

    mcse_block_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .clr   (pk_clr),
        .load  (pk_load),
        .data  (bif.bus_rdData),
        .beat  (beat),
        .last  (pk_last),
        .block (block_q)
    );

    // Iterating downward leaves the lowest eligible index as the winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_IP - 1; i >= 0; i--)
            if (mask_q[i] && IP_W'(i) >= cur_ip) begin
                sel_found = 1'b1;
                sel_idx   = IP_W'(i);
            end
    end

    always_comb begin
        gold = '0;
        for (int i = 0; i < NUM_IP; i++)
            if (cur_ip == IP_W'(i))
                gold = golden_digest[i*DIGEST_W +: DIGEST_W];
    end

    assign waiting   = (state == S_RD_WAIT) || (state == S_SHA_ISSUE) || (state == S_SHA_WAIT);
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    // The core may still show the previous block's ready/valid right after a command.
    assign hold_done = (tmo_cnt >= TMO_W'(2));
    assign addr_full = beat_addr(64'(BASE_ADDR), 64'(IP_STRIDE), 64'(cur_ip_nx), 64'(blk_nx),
                                 64'(addr_beat));

    always_comb begin
        state_nx  = state;
        cur_ip_nx = cur_ip;
        blk_nx    = blk;
        ip_end_nx = ip_end;
        addr_beat = beat;
        pk_clr    = 1'b0;
        pk_load   = 1'b0;
        clr_res   = 1'b0;
        set_pass  = 1'b0;
        set_fail  = 1'b0;
        set_tmo   = 1'b0;
        ip_fail   = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr_res   = 1'b1;
                    cur_ip_nx = '0;
                    ip_end_nx = 1'b0;
                    state_nx  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found && !ip_end) begin
                    cur_ip_nx = sel_idx;
                    blk_nx    = '0;
                    addr_beat = '0;
                    pk_clr    = 1'b1;
                    state_nx  = S_RD_REQ;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_RD_REQ: state_nx = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bif.bus_done) begin
                    pk_load = 1'b1;
                    if (pk_last) begin
                        state_nx = S_SHA_ISSUE;
                    end else begin
                        addr_beat = beat + BEAT_CNT_W'(1);
                        state_nx  = S_RD_REQ;
                    end
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    ip_fail = 1'b1;
                end
            end
            S_SHA_ISSUE: begin
                if (bif.sha_ready) begin
                    state_nx = S_SHA_WAIT;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    ip_fail = 1'b1;
                end
            end
            S_SHA_WAIT: begin
                if (hold_done && bif.sha_ready && bif.sha_digest_valid) begin
                    if (blk == BLK_W'(BLOCKS_PER_IMG - 1)) begin
                        state_nx = S_COMPARE;
                    end else begin
                        blk_nx    = blk + BLK_W'(1);
                        addr_beat = '0;
                        pk_clr    = 1'b1;
                        state_nx  = S_RD_REQ;
                    end
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    ip_fail = 1'b1;
                end
            end
            S_COMPARE: begin
                if (bif.sha_digest == gold) begin
                    set_pass = 1'b1;
                    advance  = 1'b1;
                end else begin
                    ip_fail = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (ip_fail) begin
            set_fail = 1'b1;
            if (lock_q) state_nx = S_DONE;
            else        advance  = 1'b1;
        end

        // ip_end stops SELECT from rescanning after the index wraps past the last IP.
        if (advance) begin
            state_nx = S_SELECT;
            if (cur_ip == IP_W'(NUM_IP - 1)) begin
                cur_ip_nx = '0;
                ip_end_nx = 1'b1;
            end else begin
                cur_ip_nx = cur_ip + IP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_ip      <= '0;
            blk         <= '0;
            ip_end      <= 1'b0;
            mask_q      <= '0;
            lock_q      <= 1'b0;
            tmo_cnt     <= '0;
            pass_vec    <= '0;
            fail_vec    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus_go_q    <= 1'b0;
            bus_addr_q  <= '0;
            sha_init_q  <= 1'b0;
            sha_next_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cur_ip <= cur_ip_nx;
            blk    <= blk_nx;
            ip_end <= ip_end_nx;

            if (state_nx != state) tmo_cnt <= '0;
            else if (waiting)      tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (clr_res) begin
                pass_vec    <= '0;
                fail_vec    <= '0;
                timeout_err <= 1'b0;
                mask_q      <= ip_mask;
                lock_q      <= lock_on_fail;
            end
            if (set_pass) pass_vec[cur_ip] <= 1'b1;
            if (set_fail) fail_vec[cur_ip] <= 1'b1;
            if (set_tmo)  timeout_err      <= 1'b1;

            busy     <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done     <= (state_nx == S_DONE);
            bus_go_q <= (state_nx == S_RD_REQ);
            if (state_nx == S_RD_REQ) bus_addr_q <= addr_full[ADDR_W-1:0];
            sha_init_q <= (state == S_SHA_ISSUE) && (state_nx == S_SHA_WAIT) && (blk == '0);
            sha_next_q <= (state == S_SHA_ISSUE) && (state_nx == S_SHA_WAIT) && (blk != '0);
        end
    end

endmodule

// File: tb/tb_mcse_auth_sequencer.sv
// Directed bench: bus/SHA behavioural models, address and result scoreboards.
module tb_mcse_auth_sequencer;
    import mcse_auth_pkg::*;

    localparam int          NUM_IP  = 4;
    localparam int          BLOCKS  = 2;
    localparam int          ADDR_W  = 32;
    localparam int          TMO     = 16;
    localparam int          BUS_LAT = 3;
    localparam int          SHA_LAT = 4;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam logic [31:0] STRIDE  = 32'h0000_1000;

    typedef struct packed {
        logic [NUM_IP-1:0] pass;
        logic [NUM_IP-1:0] fail;
        logic              tmo;
    } res_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       lock_on_fail = 1'b0;
    logic [NUM_IP-1:0]          ip_mask = '0;
    logic [NUM_IP*256-1:0]      golden = '0;
    logic                       busy, done, timeout_err;
    logic [NUM_IP-1:0]          pass_vec, fail_vec;
    logic [1:0]                 cur_ip;
    int                         n_cmp = 0;
    int                         n_err = 0;
    logic [31:0]                addr_q[$];
    res_t                       res_q[$];
    logic                       withhold_en = 1'b0;
    logic [31:0]                withhold_addr = '0;

    mcse_auth_sequencer_if #(.ADDR_W(ADDR_W)) bif();

    mcse_auth_sequencer #(
        .NUM_IP(NUM_IP), .BLOCKS_PER_IMG(BLOCKS), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE), .IP_STRIDE(STRIDE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ip_mask(ip_mask),
        .lock_on_fail(lock_on_fail), .golden_digest(golden), .bif(bif),
        .busy(busy), .done(done), .pass_vec(pass_vec), .fail_vec(fail_vec),
        .timeout_err(timeout_err), .cur_ip(cur_ip)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a, ~a, a ^ 32'hDEAD_BEEF, a[15:0], a[31:16]};
    endfunction

    // Stand-in for SHA-256: any deterministic chaining function exposes block order/content errors.
    function automatic logic [255:0] mix(input logic [255:0] d, input logic [511:0] b);
        return {d[254:0], d[255]} ^ b[511:256] ^ b[255:0];
    endfunction

    function automatic logic [255:0] golden_of(input int ip);
        logic [255:0] d = '0;
        logic [511:0] blk;
        logic [31:0]  a;
        for (int b = 0; b < BLOCKS; b++) begin
            for (int k = 0; k < 4; k++) begin
                a = 32'(BASE + ip * STRIDE + (b * 4 + k) * 16);
                blk[511-128*k -: 128] = mem_word(a);
            end
            d = mix(d, blk);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus-translation model: fixed latency, optional withheld address, restarts on a new request.
    logic [31:0] p_addr;
    int          p_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_cnt          <= 0;
            p_addr         <= '0;
            bif.bus_done   <= 1'b0;
            bif.bus_rdData <= '0;
        end else begin
            bif.bus_done <= 1'b0;
            if (bif.bus_go) begin
                p_addr <= bif.bus_addr;
                p_cnt  <= BUS_LAT - 1;
            end else if (p_cnt != 0) begin
                p_cnt <= p_cnt - 1;
                if (p_cnt == 1 && !(withhold_en && p_addr == withhold_addr)) begin
                    bif.bus_done   <= 1'b1;
                    bif.bus_rdData <= mem_word(p_addr);
                end
            end
        end
    end

    logic [255:0] acc;
    int           s_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bif.sha_ready        <= 1'b1;
            bif.sha_digest_valid <= 1'b0;
            acc                  <= '0;
            s_cnt                <= 0;
        end else if (bif.sha_init || bif.sha_next) begin
            bif.sha_ready        <= 1'b0;
            bif.sha_digest_valid <= 1'b0;
            s_cnt                <= SHA_LAT;
            acc                  <= mix(bif.sha_init ? 256'd0 : acc, bif.sha_block);
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) begin
                bif.sha_ready        <= 1'b1;
                bif.sha_digest_valid <= 1'b1;
            end
        end
    end
    assign bif.sha_digest = acc;

    always @(negedge clk) begin
        if (bif.bus_go) begin
            chk("bus_RW", 64'(bif.bus_RW), 64'd0);
            if (addr_q.size() == 0) begin
                chk("spurious_bus_go", 64'(bif.bus_go), 64'd0);
            end else begin
                logic [31:0] e;
                e = addr_q.pop_front();
                chk("bus_addr", 64'(bif.bus_addr), 64'(e));
            end
        end
    end

    task automatic push_addrs(input int ip, input int nbeats);
        for (int k = 0; k < nbeats; k++)
            addr_q.push_back(32'(BASE + ip * STRIDE + k * 16));
    endtask

    task automatic do_start(input logic [NUM_IP-1:0] m, input logic lk);
        @(negedge clk);
        ip_mask = m; lock_on_fail = lk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        res_t e;
        int   n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        e = res_q.pop_front();
        chk({tag, "_pass"}, 64'(pass_vec), 64'(e.pass));
        chk({tag, "_fail"}, 64'(fail_vec), 64'(e.fail));
        chk({tag, "_tmo"},  64'(timeout_err), 64'(e.tmo));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NUM_IP; i++) golden[i*256 +: 256] = golden_of(i);

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass_vec), 64'd0);
        chk("rst_fail", 64'(fail_vec), 64'd0);
        chk("rst_bus_go", 64'(bif.bus_go), 64'd0);
        chk("rst_bus_addr", 64'(bif.bus_addr), 64'd0);
        rst = 1'b0;

        // Mask 1011, all match; includes start latency and an ignored mid-run start.
        push_addrs(0, 8); push_addrs(1, 8); push_addrs(3, 8);
        res_q.push_back('{pass: 4'b1011, fail: 4'b0000, tmo: 1'b0});
        @(negedge clk);
        ip_mask = 4'b1011; lock_on_fail = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_bus_go", 64'(bif.bus_go), 64'd0);
        @(negedge clk);
        chk("c2_bus_go", 64'(bif.bus_go), 64'd1);
        repeat (40) @(negedge clk);
        ip_mask = 4'b0000; lock_on_fail = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run_match");

        // IP 2 golden corrupted, no lock.
        golden[2*256] = ~golden[2*256];
        push_addrs(0, 8); push_addrs(1, 8); push_addrs(2, 8); push_addrs(3, 8);
        res_q.push_back('{pass: 4'b1011, fail: 4'b0100, tmo: 1'b0});
        do_start(4'b1111, 1'b0);
        wait_done("run_mismatch");

        // Same with lock: IP 3 must never be requested.
        push_addrs(0, 8); push_addrs(1, 8); push_addrs(2, 8);
        res_q.push_back('{pass: 4'b0011, fail: 4'b0100, tmo: 1'b0});
        do_start(4'b1111, 1'b1);
        wait_done("run_lock");
        golden[2*256] = ~golden[2*256];

        // Empty mask: done two cycles after start, no bus traffic.
        res_q.push_back('{pass: 4'b0000, fail: 4'b0000, tmo: 1'b0});
        @(negedge clk);
        ip_mask = 4'b0000; lock_on_fail = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_c1_busy", 64'(busy), 64'd1);
        chk("empty_c1_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("empty_c2_done", 64'(done), 64'd1);
        wait_done("run_empty");

        // IP 0 beat 2 never answered; IP 1 must still authenticate.
        withhold_en = 1'b1; withhold_addr = 32'h0000_0020;
        push_addrs(0, 3); push_addrs(1, 8);
        res_q.push_back('{pass: 4'b0010, fail: 4'b0001, tmo: 1'b1});
        do_start(4'b0011, 1'b0);
        begin
            int n = 0;
            while (!(bif.bus_go && bif.bus_addr == withhold_addr) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_req_seen", 64'(bif.bus_go), 64'd1);
            n = 0;
            while (!fail_vec[0] && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_latency_in_16_18", 64'(n >= 16 && n <= 18), 64'd1);
        end
        wait_done("run_timeout");
        withhold_en = 1'b0;

        // Reset while a read is outstanding, then a clean full run.
        push_addrs(0, 1);
        do_start(4'b1111, 1'b0);
        begin
            int n = 0;
            while (!bif.bus_go && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_bus_addr", 64'(bif.bus_addr), 64'd0);
        chk("mid_rst_cur_ip", 64'(cur_ip), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_addrs(0, 8); push_addrs(1, 8); push_addrs(2, 8); push_addrs(3, 8);
        res_q.push_back('{pass: 4'b1111, fail: 4'b0000, tmo: 1'b0});
        do_start(4'b1111, 1'b0);
        wait_done("run_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
